// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port 32-bit data RAM responder with byte-lane stores, 1-cycle registered ack and error flagging.
// Optional request counters are enabled by defining DATA_MEM_STATS_EN.
module data_mem_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_err_o
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] err_cnt_o
`endif
);
  logic [31:0]           w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_oor;
  logic                  w_legal;
  logic                  w_ok;
  logic                  w_err;
  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [31:0]           r_data;
  logic                  r_ack;
  logic                  r_err;
  assign w_off   = mem_addr_i - BASE_ADDR;
  assign w_idx   = w_off[ADDR_WIDTH+1:2];
  // Addresses below the base wrap to huge offsets, but the explicit compare keeps that intent obvious.
  assign w_oor   = (mem_addr_i < BASE_ADDR) || (w_off[31:ADDR_WIDTH+2] != '0);
  assign w_legal = {mem_sel_i, w_off[1:0]} inside {6'b1111_00, 6'b0011_00, 6'b1100_10,
                   6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11};
  assign w_ok    = mem_ce_i & ~rst & w_legal & ~w_oor;
  assign w_err   = mem_ce_i & ~rst & ~(w_legal & ~w_oor);
  always_ff @(posedge clk) begin
    if (w_ok && mem_we_i)
      for (int i = 0; i < 4; i++)
        if (mem_sel_i[i]) r_mem[w_idx][8*i +: 8] <= mem_data_i[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else begin
      r_ack <= mem_ce_i;
      r_err <= w_err;
      if (mem_ce_i) r_data <= (w_ok && !mem_we_i) ? r_mem[w_idx] : '0;
    end
  end
  assign mem_ack_o  = r_ack;
  assign mem_err_o  = r_err;
  assign mem_data_o = r_data;
`ifdef DATA_MEM_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_ok && !mem_we_i && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_ok && mem_we_i && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 32'd1;
      if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end
  assign rd_cnt_o  = r_rd_cnt;
  assign wr_cnt_o  = r_wr_cnt;
  assign err_cnt_o = r_err_cnt;
`endif
endmodule
